// File: rtl/lane_rx_buffer.sv
// Receive side of the 4-lane routed word channel: one FIFO per lane with
// first-word-fall-through heads, a pop handshake and sticky error flags.
// Optional build macro LANE_RX_STATS_EN adds the saturating rx_total counter.
module lane_rx_buffer #(
  parameter int unsigned WORD_W = 10,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AW     = 2,
  parameter int unsigned AF_TH  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        state,
  input  logic [WORD_W-1:0] In0,
  input  logic [WORD_W-1:0] In1,
  input  logic [WORD_W-1:0] In2,
  input  logic [WORD_W-1:0] In3,
  input  logic [3:0]        pop,
  output logic [WORD_W-1:0] data_out0,
  output logic [WORD_W-1:0] data_out1,
  output logic [WORD_W-1:0] data_out2,
  output logic [WORD_W-1:0] data_out3,
  output logic [3:0]        empty,
  output logic [3:0]        almost_full,
  output logic [3:0]        full,
  output logic [3:0]        overflow_err,
  output logic [3:0]        dest_err
`ifdef LANE_RX_STATS_EN
  ,
  output logic [15:0]       rx_total
`endif
);

  localparam logic [AW:0]    LpDepth = (AW + 1)'(DEPTH);
  localparam logic [AW:0]    LpAfTh  = (AW + 1)'(AF_TH);
  localparam logic [3:0]     StFlush = 4'b0001;

  logic [WORD_W-1:0] r_mem    [4][DEPTH];
  logic [AW-1:0]     r_wr_ptr [4];
  logic [AW-1:0]     r_rd_ptr [4];
  logic [AW:0]       r_count  [4];
  logic [3:0]        r_ovf;
  logic [3:0]        r_dst;

  logic [WORD_W-1:0] w_in   [4];
  logic [WORD_W-1:0] w_head [4];
  logic              w_flush;
  logic [3:0]        w_full;
  logic [3:0]        w_push_req;
  logic [3:0]        w_do_push;
  logic [3:0]        w_do_pop;
  logic [3:0]        w_ovf_set;
  logic [3:0]        w_dst_set;

  assign w_in[0] = In0;
  assign w_in[1] = In1;
  assign w_in[2] = In2;
  assign w_in[3] = In3;

  assign w_flush = (state == StFlush);

  // Status flags and gated FWFT heads, all derived from the registered count.
  always_comb begin
    empty       = '0;
    almost_full = '0;
    w_full      = '0;
    for (int i = 0; i < 4; i++) begin
      empty[i]       = (r_count[i] == '0);
      almost_full[i] = (r_count[i] >= LpAfTh);
      w_full[i]      = (r_count[i] == LpDepth);
      w_head[i]      = empty[i] ? '0 : r_mem[i][r_rd_ptr[i]];
    end
  end

  assign full      = w_full;
  assign data_out0 = w_head[0];
  assign data_out1 = w_head[1];
  assign data_out2 = w_head[2];
  assign data_out3 = w_head[3];

  // Per-lane push/pop decisions; a flush masks every input and pop.
  always_comb begin
    w_push_req = '0;
    w_do_push  = '0;
    w_do_pop   = '0;
    w_ovf_set  = '0;
    w_dst_set  = '0;
    for (int i = 0; i < 4; i++) begin
      if (!w_flush) begin
        w_do_pop[i] = pop[i] && (r_count[i] != '0);
        if (w_in[i] != '0) begin
          if (w_in[i][WORD_W-1 -: 2] == 2'(i)) begin
            w_push_req[i] = 1'b1;
          end else begin
            w_dst_set[i] = 1'b1;
          end
        end
        // A full lane still accepts a word when its head leaves on the same edge.
        w_do_push[i] = w_push_req[i] && (!w_full[i] || pop[i]);
        w_ovf_set[i] = w_push_req[i] && w_full[i] && !pop[i];
      end
    end
  end

  // Pointer, count and sticky error state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
      r_ovf <= '0;
      r_dst <= '0;
    end else if (w_flush) begin
      for (int i = 0; i < 4; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_do_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + AW'(1);
        if (w_do_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + AW'(1);
        case ({w_do_push[i], w_do_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + (AW + 1)'(1);
          2'b01:   r_count[i] <= r_count[i] - (AW + 1)'(1);
          default: r_count[i] <= r_count[i];
        endcase
      end
      r_ovf <= r_ovf | w_ovf_set;
      r_dst <= r_dst | w_dst_set;
    end
  end

  // Word storage; contents need no reset because heads are gated by count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!reset && w_do_push[i]) r_mem[i][r_wr_ptr[i]] <= w_in[i];
    end
  end

  assign overflow_err = r_ovf;
  assign dest_err     = r_dst;

`ifdef LANE_RX_STATS_EN
  logic [15:0] r_rx_total;
  logic [16:0] w_rx_sum;

  assign w_rx_sum = {1'b0, r_rx_total} + 17'(w_do_push[0]) + 17'(w_do_push[1])
                  + 17'(w_do_push[2]) + 17'(w_do_push[3]);

  // Accepted-word counter; survives flush and sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_total <= '0;
    end else if (w_rx_sum[16]) begin
      r_rx_total <= 16'hFFFF;
    end else begin
      r_rx_total <= w_rx_sum[15:0];
    end
  end

  assign rx_total = r_rx_total;
`endif

endmodule
